// File: rtl/issue_select_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_n_pkg
// Description : Shared types and constants for the multi-port issue stage:
//               reservation-station entry, control bits and the per-lane
//               issue/execute register.
// Revision    : 1.0
// ============================================================================
package issue_select_n_pkg;

    localparam int RS_SIZE = 8;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;
    localparam int RS_ID_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic       alusrc;
        logic       memwr;
        logic       memrd;
        logic       regwr;
        logic [3:0] aluop;
    } ctrl_bits_t;

    typedef struct packed {
        logic               busy;
        logic [TAG_W-1:0]   tag_1;
        logic [TAG_W-1:0]   tag_2;
        logic [DATA_W-1:0]  value_1;
        logic [DATA_W-1:0]  value_2;
        logic [DATA_W-1:0]  imm;
        ctrl_bits_t         ctrl_bits;
        logic [RS_ID_W-1:0] id;
        logic [TAG_W-1:0]   tag;
    } rs_entry;

    typedef struct packed {
        logic [DATA_W-1:0]  sourceA;
        logic [DATA_W-1:0]  sourceB;
        logic [DATA_W-1:0]  data;
        ctrl_bits_t         ctrl_bits;
        logic [RS_ID_W-1:0] rs_id;
        logic [TAG_W-1:0]   tag;
    } issue_execute_register;

endpackage
`default_nettype wire

// File: rtl/issue_select_n_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_n_if
// Description : Bundle between RS array / CDB / execute lanes and the
//               issue-select stage. slave = issue stage, master = environment.
// Revision    : 1.0
// ============================================================================
interface issue_select_n_if
    import issue_select_n_pkg::*;
#(
    parameter int RS_DEPTH    = RS_SIZE,
    parameter int ISSUE_WIDTH = 2
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    rs_entry               [RS_DEPTH-1:0]    res_stations;
    logic                                    alloc_valid;
    logic                  [IDX_W-1:0]       alloc_idx;
    logic                                    cdb_valid;
    logic                  [TAG_W-1:0]       cdb_tag;
    logic                  [DATA_W-1:0]      cdb_value;
    logic                                    flush;
    logic                  [ISSUE_WIDTH-1:0] exe_ready;
    logic                  [RS_DEPTH-1:0]    issue_grant;
    logic                  [ISSUE_WIDTH-1:0] iss_valid;
    issue_execute_register [ISSUE_WIDTH-1:0] iss_exe_reg;

    modport slave (
        input  res_stations, alloc_valid, alloc_idx,
        input  cdb_valid, cdb_tag, cdb_value, flush, exe_ready,
        output issue_grant, iss_valid, iss_exe_reg
    );

    modport master (
        output res_stations, alloc_valid, alloc_idx,
        output cdb_valid, cdb_tag, cdb_value, flush, exe_ready,
        input  issue_grant, iss_valid, iss_exe_reg
    );
endinterface
`default_nettype wire

// File: rtl/issue_select_n_age_matrix.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_n_age_matrix
// Description : Age matrix (age[i][j]=1 : j older than i) plus sequential
//               oldest-first pick for each issue port.
// Revision    : 1.0
// ============================================================================
module issue_select_n_age_matrix
    import issue_select_n_pkg::*;
#(
    parameter int RS_DEPTH    = RS_SIZE,
    parameter int ISSUE_WIDTH = 2,
    parameter int IDX_W       = $clog2(RS_DEPTH)
) (
    input  wire logic                                   clk,
    input  wire logic                                   reset,
    input  wire logic                                   flush_i,
    input  wire logic                                   alloc_valid_i,
    input  wire logic [IDX_W-1:0]                       alloc_idx_i,
    input  wire logic [RS_DEPTH-1:0]                    busy_i,
    input  wire logic [RS_DEPTH-1:0]                    ready_i,
    input  wire logic [ISSUE_WIDTH-1:0]                 port_free_i,
    input  wire logic                                   enable_i,
    output logic      [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]   oldest_onehot_o
);

    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_d;
    logic [RS_DEPTH-1:0]               alloc_oh;
    logic [RS_DEPTH-1:0]               remaining;
    logic [RS_DEPTH-1:0]               cand;
    logic [RS_DEPTH-1:0]               pick;

    assign alloc_oh = RS_DEPTH'(1) << alloc_idx_i;

    // New entry becomes younger than every busy entry; nobody is younger than it.
    always_comb begin
        age_d = age_q;
        if (flush_i) begin
            age_d = '0;
        end else if (alloc_valid_i) begin
            for (int r = 0; r < RS_DEPTH; r++) begin
                age_d[r][alloc_idx_i] = 1'b0;
            end
            age_d[alloc_idx_i] = busy_i & ~alloc_oh;
        end
    end

    // Age matrix register.
    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Port-by-port pick: oldest remaining request, lowest index on equal age.
    always_comb begin
        remaining       = ready_i & {RS_DEPTH{enable_i}};
        cand            = '0;
        pick            = '0;
        oldest_onehot_o = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                cand[i] = remaining[i] && ((age_q[i] & remaining) == '0);
            end
            pick = cand & (~cand + RS_DEPTH'(1));
            if (port_free_i[p]) begin
                oldest_onehot_o[p] = pick;
                remaining          = remaining & ~pick;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_select_n.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_n
// Description : Multi-port issue select with CDB wakeup bypass and
//               registered per-lane issue/execute registers.
// Revision    : 1.0
// ============================================================================
module issue_select_n
    import issue_select_n_pkg::*;
#(
    parameter int RS_DEPTH    = RS_SIZE,
    parameter int ISSUE_WIDTH = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    issue_select_n_if.slave   isel
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]                  busy;
    logic [RS_DEPTH-1:0]                  ready;
    logic [RS_DEPTH-1:0][DATA_W-1:0]      op1;
    logic [RS_DEPTH-1:0][DATA_W-1:0]      op2;
    logic [ISSUE_WIDTH-1:0]               port_free;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0] grant_port;
    logic                                 enable;

    logic                  [ISSUE_WIDTH-1:0] iss_valid_q;
    logic                  [ISSUE_WIDTH-1:0] iss_valid_d;
    issue_execute_register [ISSUE_WIDTH-1:0] iss_exe_reg_q;
    issue_execute_register [ISSUE_WIDTH-1:0] iss_exe_reg_d;

    // Readiness and operand values, with the current CDB broadcast bypassed in.
    always_comb begin
        busy  = '0;
        ready = '0;
        op1   = '0;
        op2   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy[i]  = isel.res_stations[i].busy;
            ready[i] = isel.res_stations[i].busy
                && ((isel.res_stations[i].tag_1 == '0)
                    || (isel.cdb_valid && (isel.cdb_tag == isel.res_stations[i].tag_1)))
                && ((isel.res_stations[i].tag_2 == '0)
                    || (isel.cdb_valid && (isel.cdb_tag == isel.res_stations[i].tag_2)));
            op1[i] = (isel.cdb_valid && (isel.res_stations[i].tag_1 != '0)
                      && (isel.cdb_tag == isel.res_stations[i].tag_1))
                     ? isel.cdb_value : isel.res_stations[i].value_1;
            op2[i] = (isel.cdb_valid && (isel.res_stations[i].tag_2 != '0)
                      && (isel.cdb_tag == isel.res_stations[i].tag_2))
                     ? isel.cdb_value : isel.res_stations[i].value_2;
        end
    end

    assign port_free = ~iss_valid_q | isel.exe_ready;
    assign enable    = !reset && !isel.flush;

    issue_select_n_age_matrix #(
        .RS_DEPTH    (RS_DEPTH),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .IDX_W       (IDX_W)
    ) u_age_matrix (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (isel.flush),
        .alloc_valid_i   (isel.alloc_valid),
        .alloc_idx_i     (isel.alloc_idx),
        .busy_i          (busy),
        .ready_i         (ready),
        .port_free_i     (port_free),
        .enable_i        (enable),
        .oldest_onehot_o (grant_port)
    );

    // Per-entry grant back to the RS: union of every port's one-hot pick.
    always_comb begin
        isel.issue_grant = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            isel.issue_grant = isel.issue_grant | grant_port[p];
        end
    end

    // Lane next state: load on grant, drain on accept, otherwise stall.
    always_comb begin
        iss_valid_d   = iss_valid_q;
        iss_exe_reg_d = iss_exe_reg_q;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (isel.flush) begin
                iss_valid_d[p] = 1'b0;
            end else if (|grant_port[p]) begin
                iss_valid_d[p] = 1'b1;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (grant_port[p][i]) begin
                        iss_exe_reg_d[p].sourceA   = op1[i];
                        iss_exe_reg_d[p].sourceB   = isel.res_stations[i].ctrl_bits.alusrc
                                                     ? isel.res_stations[i].imm : op2[i];
                        iss_exe_reg_d[p].data      = isel.res_stations[i].ctrl_bits.memwr
                                                     ? op2[i] : '0;
                        iss_exe_reg_d[p].ctrl_bits = isel.res_stations[i].ctrl_bits;
                        iss_exe_reg_d[p].rs_id     = isel.res_stations[i].id;
                        iss_exe_reg_d[p].tag       = isel.res_stations[i].tag;
                    end
                end
            end else if (isel.exe_ready[p]) begin
                iss_valid_d[p] = 1'b0;
            end
        end
    end

    // Lane registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid_q   <= '0;
            iss_exe_reg_q <= '0;
        end else begin
            iss_valid_q   <= iss_valid_d;
            iss_exe_reg_q <= iss_exe_reg_d;
        end
    end

    assign isel.iss_valid   = iss_valid_q;
    assign isel.iss_exe_reg = iss_exe_reg_q;

endmodule
`default_nettype wire

// File: doc/issue_select_n.md
Name: issue_select_n

Overview:
- Parametrised multi-port successor to the single-port issue stage.
- Each cycle it selects up to ISSUE_WIDTH ready reservation-station entries, oldest first, using an internal age matrix.
- Same-cycle CDB wakeup bypass lets an entry whose operand arrives this cycle issue immediately.
- Sits between the RS array and the execute units; each port has a registered issue_execute_register with a valid/ready handshake, and per-entry grants go back to the RS so it can clear busy.

Parameters:
- RS_DEPTH, 8, number of reservation-station entries.
- ISSUE_WIDTH, 2, number of issue ports / execute lanes.
- TAG_W, 4, tag width; tag value 0 means "operand present".
- DATA_W, 32, operand/immediate width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- res_stations  in  rs_entry[RS_DEPTH]  current RS contents (busy, tag_1, tag_2, value_1, value_2, imm, ctrl_bits, id, tag).
- alloc_valid  in  1  an RS entry is written this cycle.
- alloc_idx  in  $clog2(RS_DEPTH)  index of the entry being allocated.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag; never 0 when valid.
- cdb_value  in  DATA_W  broadcast value.
- flush  in  1  pipeline flush.
- exe_ready  in  ISSUE_WIDTH  execute lane p accepts its register this cycle.
- issue_grant  out  RS_DEPTH  combinational one-hot-per-port grant vector; RS clears busy at the next edge.
- iss_valid  out  ISSUE_WIDTH  registered: lane p holds a valid instruction.
- iss_exe_reg  out  issue_execute_register[ISSUE_WIDTH]  registered payload per lane.

Behaviour:
- Reset (synchronous): iss_valid=0, every iss_exe_reg=0, age matrix cleared. issue_grant is 0 whenever reset is high.
- Readiness of entry i: busy, and for each operand k either tag_k==0, or (cdb_valid and cdb_tag==tag_k).
- Bypassed operands take cdb_value instead of value_k.
- Age matrix age[i][j]=1 means j is older than i.
  - On alloc_valid at an edge: row alloc_idx <= {busy bits of all other entries}, and column alloc_idx <= 0 in every row.
  - An allocated entry is not selectable in its allocation cycle (busy is not yet set).
- Port-free: lane p can take a new instruction when !iss_valid[p] or exe_ready[p].
- Selection is sequential over ports 0..ISSUE_WIDTH-1:
  - Port p takes the ready, not-yet-granted entry with no older ready not-yet-granted entry.
  - If port p is not free, it grants nothing and later ports still select. There is no compaction to lower ports.
- Lane register update at the edge:
  - If port p granted entry i: iss_valid[p] <= 1.
  - sourceA <= operand1.
  - sourceB <= imm if ctrl_bits.alusrc, else operand2.
  - data <= operand2 if ctrl_bits.memwr, else 0.
  - ctrl_bits, rs_id, tag are copied from the entry.
  - Else if exe_ready[p]: iss_valid[p] <= 0 and the payload holds.
  - Else: the lane holds unchanged (stall).
- Latency: entry ready in cycle N gives iss_valid high at the N+1 edge. A CDB wakeup in cycle N also issues at the N+1 edge.
- Handshake: the payload is stable while iss_valid[p] && !exe_ready[p]. A transfer occurs at the edge where both are high.
- Back-to-back issue on a lane at full rate is supported, since exe_ready frees the slot in the same cycle.
- flush: at the edge, iss_valid <= 0, age matrix <= 0, and issue_grant is forced to 0 that cycle. flush wins over alloc and over grants.
- Simultaneous alloc and grant of the same index cannot occur; grant and alloc of different indices both take effect.
- Ties cannot occur: age is a strict order among busy entries. Entries with an all-zero row are treated as oldest, with lowest index breaking ties (post-flush refill case).

Decomposition:
- Shared package holds rs_entry, issue_execute_register, ctrl_bits struct, and the RS_SIZE/tag-width constants; these are reused unchanged.
- One natural sub-module: age_matrix (RS_DEPTH parameter). It takes alloc/flush/busy and provides a combinational oldest_onehot(request_mask) function output per port.

Test Plan:
- Reset held 2 cycles with busy entries present -> iss_valid=0, issue_grant=0, payload all zero.
- Allocate entries 5,2,7 in that order, all ready, exe_ready=2'b11 -> cycle1 grants 5 (port0) and 2 (port1); cycle2 grants 7 (port0).
- Entry 3 waits on tag_1=4; cdb_valid with tag 4, value 0xDEAD -> grant the same cycle, next edge sourceA=0xDEAD.
- Lane0 valid with exe_ready[0]=0 for 3 cycles, two ready entries -> lane0 payload stable, port1 takes the oldest, other entry waits, no grant to port0.
- Store entry (memwr=1, alusrc=1, imm=0x10, value_2=0x55) -> sourceB=0x10, data=0x55.
- flush while 4 entries are busy and lanes valid -> next cycle iss_valid=0, issue_grant=0 during flush, age rows zero.
